// File: rtl/regfile_write_scheduler_if.sv
// Requester-side handshake bundle for the register-file write scheduler.
// The requesters drive valid/addr/data; the scheduler answers with ready.
interface regfile_write_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Round-robin scheduler granting up to two distinct-address writes per cycle
// onto the two registered write ports of the 8x16 register file.
module regfile_write_scheduler #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_write_scheduler_if.slave  req_if,
    output logic                      we1,
    output logic [ADDR_W-1:0]         write_addr1,
    output logic [DATA_W-1:0]         write_data1,
    output logic                      we2,
    output logic [ADDR_W-1:0]         write_addr2,
    output logic [DATA_W-1:0]         write_data2,
    output logic [15:0]               conflict_cnt
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  rr_ptr_r;
    logic              we1_r;
    logic              we2_r;
    logic [ADDR_W-1:0] addr1_r;
    logic [ADDR_W-1:0] addr2_r;
    logic [DATA_W-1:0] data1_r;
    logic [DATA_W-1:0] data2_r;
    logic [15:0]       conflict_cnt_r;

    logic [PTR_W-1:0]  idx_s;
    logic [PTR_W-1:0]  a_idx_s;
    logic [PTR_W-1:0]  b_idx_s;
    logic              a_found_s;
    logic              b_found_s;
    logic              defer_s;
    logic [ADDR_W-1:0] a_addr_s;
    logic [ADDR_W-1:0] b_addr_s;
    logic [DATA_W-1:0] a_data_s;
    logic [DATA_W-1:0] b_data_s;
    logic [NREQ-1:0]   ready_s;

    // Both operands are below NREQ, so one conditional subtract wraps the sum.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned       off);
        int unsigned sum_v;
        sum_v = 32'(base) + off;
        if (sum_v >= 32'(NREQ)) begin
            sum_v = sum_v - 32'(NREQ);
        end else begin
            sum_v = sum_v;
        end
        return sum_v[PTR_W-1:0];
    endfunction

    // Scan from rr_ptr: first valid is slot A, next valid with a different address is slot B.
    always_comb begin
        idx_s     = '0;
        a_idx_s   = '0;
        b_idx_s   = '0;
        a_found_s = 1'b0;
        b_found_s = 1'b0;
        defer_s   = 1'b0;
        a_addr_s  = '0;
        b_addr_s  = '0;
        a_data_s  = '0;
        b_data_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = wrap_add(rr_ptr_r, 32'(k));
            if (req_if.req_valid[idx_s]) begin
                if (!a_found_s) begin
                    a_found_s = 1'b1;
                    a_idx_s   = idx_s;
                    a_addr_s  = req_if.req_addr[ADDR_W*32'(idx_s) +: ADDR_W];
                    a_data_s  = req_if.req_data[DATA_W*32'(idx_s) +: DATA_W];
                end else if (req_if.req_addr[ADDR_W*32'(idx_s) +: ADDR_W] == a_addr_s) begin
                    defer_s = 1'b1;
                end else if (!b_found_s) begin
                    b_found_s = 1'b1;
                    b_idx_s   = idx_s;
                    b_addr_s  = req_if.req_addr[ADDR_W*32'(idx_s) +: ADDR_W];
                    b_data_s  = req_if.req_data[DATA_W*32'(idx_s) +: DATA_W];
                end else begin
                    defer_s = defer_s;
                end
            end else begin
                defer_s = defer_s;
            end
        end
    end

    // Ready is the one-hot of the two slots, suppressed entirely during reset.
    always_comb begin
        ready_s = '0;
        if (rst) begin
            ready_s = '0;
        end else begin
            if (a_found_s) begin
                ready_s[a_idx_s] = 1'b1;
            end else begin
                ready_s = ready_s;
            end
            if (b_found_s) begin
                ready_s[b_idx_s] = 1'b1;
            end else begin
                ready_s = ready_s;
            end
        end
    end

    // Port registers, round-robin pointer and saturating conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r       <= '0;
            we1_r          <= 1'b0;
            we2_r          <= 1'b0;
            addr1_r        <= '0;
            addr2_r        <= '0;
            data1_r        <= '0;
            data2_r        <= '0;
            conflict_cnt_r <= 16'h0000;
        end else begin
            we1_r <= a_found_s;
            we2_r <= b_found_s;
            if (a_found_s) begin
                addr1_r <= a_addr_s;
                data1_r <= a_data_s;
            end
            if (b_found_s) begin
                addr2_r  <= b_addr_s;
                data2_r  <= b_data_s;
                rr_ptr_r <= wrap_add(b_idx_s, 32'd1);
            end else if (a_found_s) begin
                rr_ptr_r <= wrap_add(a_idx_s, 32'd1);
            end
            if (defer_s && (conflict_cnt_r != 16'hFFFF)) begin
                conflict_cnt_r <= conflict_cnt_r + 16'h0001;
            end
        end
    end

    assign req_if.req_ready = ready_s;
    assign we1              = we1_r;
    assign write_addr1      = addr1_r;
    assign write_data1      = data1_r;
    assign we2              = we2_r;
    assign write_addr2      = addr2_r;
    assign write_data2      = data2_r;
    assign conflict_cnt     = conflict_cnt_r;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed plan steps followed by random
// traffic, all checked against a transaction-level model and a modelled file.
module tb_regfile_write_scheduler;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_write_scheduler_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();

    logic              we1, we2;
    logic [ADDR_W-1:0] write_addr1, write_addr2;
    logic [DATA_W-1:0] write_data1, write_data2;
    logic [15:0]       conflict_cnt;

    regfile_write_scheduler #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (req_if.slave),
        .we1          (we1),
        .write_addr1  (write_addr1),
        .write_data1  (write_data1),
        .we2          (we2),
        .write_addr2  (write_addr2),
        .write_data2  (write_data2),
        .conflict_cnt (conflict_cnt)
    );

    // The 8x16 register file fed by the scheduler; port 2 wins a same-address tie.
    logic [DATA_W-1:0] file_q [8];
    always @(posedge clk) begin
        if (we1 === 1'b1) file_q[write_addr1] <= write_data1;
        if (we2 === 1'b1) file_q[write_addr2] <= write_data2;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side state
    bit              v [NREQ];
    int              a [NREQ];
    int              d [NREQ];
    logic [NREQ-1:0] last_ready;

    // Reference model state
    int m_rr, m_a1, m_d1, m_a2, m_d2, m_cnt;
    bit m_we1, m_we2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_if.req_valid[i]                  = v[i];
            req_if.req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(a[i]);
            req_if.req_data[i*DATA_W +: DATA_W]  = DATA_W'(d[i]);
        end
    endtask

    // Walk requesters in priority order starting at the model pointer.
    task automatic model_select(output bit af, output bit bf, output int ai,
                                output int bi, output bit deferred);
        af = 0; bf = 0; ai = 0; bi = 0; deferred = 0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (v[i]) begin
                if (!af) begin
                    af = 1; ai = i;
                end else if (a[i] == a[ai]) begin
                    deferred = 1;
                end else if (!bf) begin
                    bf = 1; bi = i;
                end
            end
        end
    endtask

    // One clock cycle: check ready mid-cycle, advance the model, check ports after the edge.
    task automatic step(input string tag);
        bit af, bf, dfr;
        int ai, bi;
        logic [NREQ-1:0] exp_rdy;
        drive();
        #1;
        model_select(af, bf, ai, bi, dfr);
        exp_rdy = '0;
        if (!rst && af) exp_rdy[ai] = 1'b1;
        if (!rst && bf) exp_rdy[bi] = 1'b1;
        last_ready = req_if.req_ready;
        chk({tag, ".ready"}, 32'(req_if.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (rst) begin
            m_rr = 0; m_we1 = 0; m_we2 = 0;
            m_a1 = 0; m_d1 = 0; m_a2 = 0; m_d2 = 0; m_cnt = 0;
        end else begin
            m_we1 = af;
            m_we2 = bf;
            if (af) begin m_a1 = a[ai]; m_d1 = d[ai]; end
            if (bf) begin m_a2 = a[bi]; m_d2 = d[bi]; end
            if (bf)      m_rr = (bi + 1) % NREQ;
            else if (af) m_rr = (ai + 1) % NREQ;
            if (dfr && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
            for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) v[i] = 0;
        end
        chk({tag, ".we1"},   32'(we1),          32'(m_we1));
        chk({tag, ".we2"},   32'(we2),          32'(m_we2));
        chk({tag, ".addr1"}, 32'(write_addr1),  32'(m_a1));
        chk({tag, ".data1"}, 32'(write_data1),  32'(m_d1));
        chk({tag, ".addr2"}, 32'(write_addr2),  32'(m_a2));
        chk({tag, ".data2"}, 32'(write_data2),  32'(m_d2));
        chk({tag, ".cnt"},   32'(conflict_cnt), 32'(m_cnt));
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin v[i] = 0; a[i] = 0; d[i] = 0; end
    endtask

    // Lone request from requester 3 used to steer the pointer back to 0.
    task automatic park_ptr_at_zero();
        clear_reqs();
        v[3] = 1; a[3] = 7; d[3] = 16'h3333;
        step("park");
        chk("park.rr", 32'(dut.rr_ptr_r), 32'd0);
    endtask

    initial begin
        m_rr = 0; m_we1 = 0; m_we2 = 0;
        m_a1 = 0; m_d1 = 0; m_a2 = 0; m_d2 = 0; m_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin v[i] = 1; a[i] = i; d[i] = 16'h5000 + i; end
        @(negedge clk);

        // Reset with every requester asking
        rst = 1'b1;
        step("rst0");
        step("rst1");
        chk("rst.ready", 32'(last_ready), 32'd0);
        chk("rst.we1", 32'(we1), 32'd0);
        chk("rst.cnt", 32'(conflict_cnt), 32'd0);
        rst = 1'b0;

        // Single requester
        clear_reqs();
        v[1] = 1; a[1] = 1; d[1] = 16'hAAAA;
        step("single");
        chk("single.ready", 32'(last_ready), 32'h2);
        chk("single.port1", {we1, 12'h000, write_addr1, write_data1}, {1'b1, 12'h000, 3'd1, 16'hAAAA});
        chk("single.we2", 32'(we2), 32'd0);
        chk("single.rr", 32'(dut.rr_ptr_r), 32'd2);
        step("single_idle");
        chk("single.file", 32'(file_q[1]), 32'hAAAA);

        // Dual grant
        park_ptr_at_zero();
        clear_reqs();
        v[0] = 1; a[0] = 2; d[0] = 16'h1111;
        v[2] = 1; a[2] = 3; d[2] = 16'h2222;
        step("dual");
        chk("dual.ready", 32'(last_ready), 32'h5);
        chk("dual.port1", {write_addr1, write_data1}, {3'd2, 16'h1111});
        chk("dual.port2", {we2, write_addr2, write_data2}, {1'b1, 3'd3, 16'h2222});
        chk("dual.rr", 32'(dut.rr_ptr_r), 32'd3);

        // Address conflict
        park_ptr_at_zero();
        clear_reqs();
        v[0] = 1; a[0] = 4; d[0] = 16'hAAAA;
        v[1] = 1; a[1] = 4; d[1] = 16'hBBBB;
        step("conf1");
        chk("conf1.ready", 32'(last_ready), 32'h1);
        chk("conf1.we2", 32'(we2), 32'd0);
        chk("conf1.cnt", 32'(conflict_cnt), 32'd1);
        step("conf2");
        chk("conf2.ready", 32'(last_ready), 32'h2);
        chk("conf2.cnt", 32'(conflict_cnt), 32'd1);
        clear_reqs();
        step("conf_idle");
        chk("conf.file", 32'(file_q[4]), 32'hBBBB);

        // Round-robin with all requesters continuously valid
        park_ptr_at_zero();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) begin v[i] = 1; a[i] = i; d[i] = $urandom_range(0, 16'hFFFF); end
            step("rr");
            chk("rr.pair", 32'(last_ready), (c % 2 == 0) ? 32'h3 : 32'hC);
        end

        // Saturation from a preloaded count
        clear_reqs();
        force dut.conflict_cnt_r = 16'hFFFE;
        m_cnt = 16'hFFFE;
        step("sat_load");
        release dut.conflict_cnt_r;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NREQ; i++) begin v[i] = 1; a[i] = 5; d[i] = 16'h0E00 + c; end
            step("sat");
            chk("sat.cnt", 32'(conflict_cnt), 32'hFFFF);
        end

        // Mid-operation reset with requester 3 pending
        clear_reqs();
        v[3] = 1; a[3] = 6; d[3] = 16'h6666;
        rst = 1'b1;
        step("mid_rst0");
        chk("mid_rst.ready0", 32'(last_ready), 32'd0);
        step("mid_rst1");
        chk("mid_rst.ready1", 32'(last_ready), 32'd0);
        rst = 1'b0;
        step("after_rst");
        chk("after_rst.ready", 32'(last_ready), 32'h8);
        chk("after_rst.port1", {we1, write_addr1, write_data1}, {1'b1, 3'd6, 16'h6666});

        // Random traffic with occasional reset
        clear_reqs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1;
                    a[i] = $urandom_range(0, 3);
                    d[i] = $urandom_range(0, 16'hFFFF);
                end
            end
            rst = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
